// File: rtl/gcd_result_display.sv
// gcd_result_display
// Output stage for the GCD processor: captures dataOut on the rising edge of
// halt, converts it to three BCD digits with a bit-serial double-dabble
// engine, and drives three seven-segment displays with optional blanking of
// leading zeros. The display holds the last completed result.
module gcd_result_display #(
    parameter bit BLANK_LEADING  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] result,
    input  logic       halt,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic       busy,
    output logic       valid
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CONVERT = 2'd1;
    localparam logic [1:0] LATCH   = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    logic [1:0]  r_state;
    logic        r_haltQ;
    logic [7:0]  r_bin;
    logic [11:0] r_bcd;
    logic [3:0]  r_cnt;
    logic [3:0]  r_ones;
    logic [3:0]  r_tens;
    logic [3:0]  r_hund;
    logic        r_busy;
    logic        r_valid;

    logic        w_capture;
    logic [11:0] w_bcdAdj;
    logic [11:0] w_bcdNext;
    logic [7:0]  w_binNext;
    logic        w_blank0;
    logic        w_blank1;
    logic        w_blank2;
    logic [6:0]  w_raw0;
    logic [6:0]  w_raw1;
    logic [6:0]  w_raw2;

    // Active-low pattern for one decimal digit; anything above 9 is blank.
    function automatic logic [6:0] segDecode(input logic [3:0] digit);
        case (digit)
            4'd0:    segDecode = 7'h40;
            4'd1:    segDecode = 7'h79;
            4'd2:    segDecode = 7'h24;
            4'd3:    segDecode = 7'h30;
            4'd4:    segDecode = 7'h19;
            4'd5:    segDecode = 7'h12;
            4'd6:    segDecode = 7'h02;
            4'd7:    segDecode = 7'h78;
            4'd8:    segDecode = 7'h00;
            4'd9:    segDecode = 7'h10;
            default: segDecode = SEG_BLANK;
        endcase
    endfunction

    assign w_capture = halt & ~r_haltQ;

    // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd,bin} left.
    always_comb begin
        w_bcdAdj = r_bcd;
        for (int n = 0; n < 3; n++) begin
            if (r_bcd[n*4 +: 4] >= 4'd5) begin
                w_bcdAdj[n*4 +: 4] = r_bcd[n*4 +: 4] + 4'd3;
            end
        end
        {w_bcdNext, w_binNext} = {w_bcdAdj, r_bin} << 1;
    end

    // Capture / convert / latch sequencer; a new capture always restarts the conversion.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_haltQ <= 1'b0;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_ones  <= '0;
            r_tens  <= '0;
            r_hund  <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_haltQ <= halt;
            if (w_capture) begin
                r_bin   <= result;
                r_bcd   <= '0;
                r_cnt   <= '0;
                r_busy  <= 1'b1;
                r_state <= CONVERT;
            end else begin
                case (r_state)
                    CONVERT: begin
                        r_bcd <= w_bcdNext;
                        r_bin <= w_binNext;
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            r_state <= LATCH;
                        end
                    end
                    LATCH: begin
                        r_ones  <= r_bcd[3:0];
                        r_tens  <= r_bcd[7:4];
                        r_hund  <= r_bcd[11:8];
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Digit blanking and segment polarity, purely from the display registers.
    always_comb begin
        w_blank0 = ~r_valid;
        w_blank1 = ~r_valid | (BLANK_LEADING && r_hund == 4'd0 && r_tens == 4'd0);
        w_blank2 = ~r_valid | (BLANK_LEADING && r_hund == 4'd0);
        w_raw0   = w_blank0 ? SEG_BLANK : segDecode(r_ones);
        w_raw1   = w_blank1 ? SEG_BLANK : segDecode(r_tens);
        w_raw2   = w_blank2 ? SEG_BLANK : segDecode(r_hund);
        if (SEG_ACTIVE_LOW) begin
            HEX0 = w_raw0;
            HEX1 = w_raw1;
            HEX2 = w_raw2;
        end else begin
            HEX0 = ~w_raw0;
            HEX1 = ~w_raw1;
            HEX2 = ~w_raw2;
        end
    end

    assign busy  = r_busy;
    assign valid = r_valid;

endmodule
